// File: rtl/sc_mmio_pkg.sv
// Shared definitions for the switch/key/LED/seven-segment MMIO controller:
// register map and the active-low seven-segment glyph table.
package sc_mmio_pkg;

  typedef enum logic [2:0] {
    REG_SW     = 3'd0,
    REG_KEY    = 3'd1,
    REG_EDGE   = 3'd2,
    REG_IE     = 3'd3,
    REG_LED    = 3'd4,
    REG_HEXVAL = 3'd5,
    REG_BLANK  = 3'd6,
    REG_TIMER  = 3'd7
  } reg_idx_e;

  localparam logic [4:0] OFF_SW     = 5'h00;
  localparam logic [4:0] OFF_KEY    = 5'h04;
  localparam logic [4:0] OFF_EDGE   = 5'h08;
  localparam logic [4:0] OFF_IE     = 5'h0C;
  localparam logic [4:0] OFF_LED    = 5'h10;
  localparam logic [4:0] OFF_HEXVAL = 5'h14;
  localparam logic [4:0] OFF_BLANK  = 5'h18;
  localparam logic [4:0] OFF_TIMER  = 5'h1C;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Segment a at bit 0, active-low.
  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/sc_mmio_ctrl_if.sv
// CPU-side register bus of the MMIO controller, including its interrupt line.
interface sc_mmio_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        sel;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, wdata, we, input  sel, rdata, irq);
  modport slave  (input  addr, wdata, we, output sel, rdata, irq);
endinterface

// File: rtl/sc_hex7seg.sv
// One seven-segment digit: hex glyph lookup with a blanking override.
module sc_hex7seg
  import sc_mmio_pkg::*;
(
  input  logic [3:0] val,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_OFF : GLYPH_TBL[val];
  end

endmodule

// File: rtl/sc_mmio_ctrl.sv
// Memory-mapped board I/O: synchronised switches, debounced keys with
// edge interrupts, LEDs, blankable hex digits and a free-running tick timer.
module sc_mmio_ctrl
  import sc_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0C00,
  parameter int          SW_W       = 10,
  parameter int          KEY_W      = 4,
  parameter int          LED_W      = 10,
  parameter int          HEX_N      = 6,
  parameter int          DEB_CYCLES = 50000,
  parameter int          TICK_DIV   = 50000
) (
  input  logic                 clock,
  input  logic                 resetn,
  sc_mmio_ctrl_if.slave        bus,
  input  logic [SW_W-1:0]      sw,
  input  logic [KEY_W-1:0]     key,
  output logic [LED_W-1:0]     led,
  output logic [7*HEX_N-1:0]   hex
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

  logic [SW_W-1:0]    sw_s1, sw_s2;
  logic [KEY_W-1:0]   key_s1, key_s2;
  logic [KEY_W-1:0]   key_act;
  logic [KEY_W-1:0]   deb_lvl, deb_lvl_nxt;
  logic [DW-1:0]      deb_cnt     [KEY_W];
  logic [DW-1:0]      deb_cnt_nxt [KEY_W];
  logic [KEY_W-1:0]   rise;

  logic [KEY_W-1:0]   edge_r, ie_r, edge_clr;
  logic [LED_W-1:0]   led_r;
  logic [4*HEX_N-1:0] hexval_r;
  logic [HEX_N-1:0]   blank_r;
  logic [31:0]        timer_r;
  logic [PW-1:0]      presc_r;
  logic               tick;

  reg_idx_e           idx;
  logic               wr;
  logic [31:0]        rdata_c;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^bus.addr[1:0];

  assign bus.sel = (bus.addr[31:5] == BASE_ADDR[31:5]);
  assign idx     = reg_idx_e'(bus.addr[4:2]);
  assign wr      = bus.we & bus.sel;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  // Count while the pressed level disagrees with the debounced one;
  // any agreement in between drops the count back to zero.
  always_comb begin
    key_act     = ~key_s2;
    deb_lvl_nxt = deb_lvl;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      deb_cnt_nxt[i] = '0;
      if (key_act[i] != deb_lvl[i]) begin
        if (deb_cnt[i] == DEB_MAX) begin
          deb_lvl_nxt[i] = key_act[i];
        end else begin
          deb_cnt_nxt[i] = deb_cnt[i] + 1'b1;
        end
      end
    end
    rise = deb_lvl_nxt & ~deb_lvl;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      deb_lvl <= '0;
      for (int unsigned i = 0; i < KEY_W; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      deb_lvl <= deb_lvl_nxt;
      for (int unsigned i = 0; i < KEY_W; i++) begin
        deb_cnt[i] <= deb_cnt_nxt[i];
      end
    end
  end

  always_comb begin
    edge_clr = '0;
    if (wr && idx == REG_EDGE) begin
      edge_clr = bus.wdata[KEY_W-1:0];
    end
  end

  assign tick = (presc_r == TICK_MAX);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      edge_r   <= '0;
      ie_r     <= '0;
      led_r    <= '0;
      hexval_r <= '0;
      blank_r  <= '1;
      timer_r  <= '0;
      presc_r  <= '0;
    end else begin
      // A new press wins over a coincident write-one-to-clear.
      edge_r <= (edge_r & ~edge_clr) | rise;
      if (wr) begin
        case (idx)
          REG_IE:     ie_r     <= bus.wdata[KEY_W-1:0];
          REG_LED:    led_r    <= bus.wdata[LED_W-1:0];
          REG_HEXVAL: hexval_r <= bus.wdata[4*HEX_N-1:0];
          REG_BLANK:  blank_r  <= bus.wdata[HEX_N-1:0];
          default:    ;
        endcase
      end
      if (wr && idx == REG_TIMER) begin
        timer_r <= bus.wdata;
        presc_r <= '0;
      end else if (tick) begin
        timer_r <= timer_r + 32'd1;
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + 1'b1;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    if (bus.sel) begin
      case (idx)
        REG_SW:     rdata_c[SW_W-1:0]    = sw_s2;
        REG_KEY:    rdata_c[KEY_W-1:0]   = deb_lvl;
        REG_EDGE:   rdata_c[KEY_W-1:0]   = edge_r;
        REG_IE:     rdata_c[KEY_W-1:0]   = ie_r;
        REG_LED:    rdata_c[LED_W-1:0]   = led_r;
        REG_HEXVAL: rdata_c[4*HEX_N-1:0] = hexval_r;
        REG_BLANK:  rdata_c[HEX_N-1:0]   = blank_r;
        REG_TIMER:  rdata_c              = timer_r;
        default:    rdata_c              = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.irq   = |(edge_r & ie_r);
  assign led       = led_r;

  for (genvar g = 0; g < HEX_N; g++) begin : g_digit
    sc_hex7seg u_digit (
      .val   (hexval_r[4*g +: 4]),
      .blank (blank_r[g]),
      .seg   (hex[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_sc_mmio_ctrl.sv
// Directed self-checking bench for sc_mmio_ctrl with short debounce/tick periods.
module tb_sc_mmio_ctrl;
  import sc_mmio_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0C00;
  localparam int HEX_N = 6;

  logic        clock;
  logic        resetn;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  led;
  logic [41:0] hex;

  int unsigned check_cnt = 0;
  int unsigned pass_cnt  = 0;

  sc_mmio_ctrl_if bus ();

  sc_mmio_ctrl #(
    .BASE_ADDR  (BASE),
    .SW_W       (10),
    .KEY_W      (4),
    .LED_W      (10),
    .HEX_N      (HEX_N),
    .DEB_CYCLES (4),
    .TICK_DIV   (3)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus),
    .sw     (sw),
    .key    (key),
    .led    (led),
    .hex    (hex)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    @(negedge clock);
    bus.addr  = BASE + 32'(off);
    bus.wdata = d;
    bus.we    = 1'b1;
    @(negedge clock);
    bus.we = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [4:0] off);
    bus.addr = BASE + 32'(off);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; sw = '0; key = 4'hF;
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_cnt++; if (led !== 10'h000) $display("FAIL reset_led got=%h exp=%h", led, 10'h000); else pass_cnt++;
    check_cnt++; if (hex !== {HEX_N{7'h7F}}) $display("FAIL reset_hex got=%h exp=%h", hex, {HEX_N{7'h7F}}); else pass_cnt++;
    check_cnt++; if (bus.irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", bus.irq); else pass_cnt++;
    rd(OFF_BLANK);
    check_cnt++; if (bus.rdata !== 32'h3F) $display("FAIL reset_blank got=%h exp=%h", bus.rdata, 32'h3F); else pass_cnt++;
    rd(OFF_TIMER);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL reset_timer got=%h exp=0", bus.rdata); else pass_cnt++;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_led_sel();
    wr(OFF_LED, 32'h0000_02A5);
    check_cnt++; if (led !== 10'h2A5) $display("FAIL led_out got=%h exp=%h", led, 10'h2A5); else pass_cnt++;
    rd(OFF_LED);
    check_cnt++; if (bus.rdata !== 32'h0000_02A5) $display("FAIL led_read got=%h exp=%h", bus.rdata, 32'h2A5); else pass_cnt++;
    bus.addr = BASE + 32'h13; #1;
    check_cnt++; if (bus.rdata !== 32'h0000_02A5) $display("FAIL led_bytealias got=%h exp=%h", bus.rdata, 32'h2A5); else pass_cnt++;
    bus.addr = BASE + 32'h20; #1;
    check_cnt++; if (bus.sel !== 1'b0 || bus.rdata !== 32'h0) $display("FAIL sel_above got=%b/%h exp=0/0", bus.sel, bus.rdata); else pass_cnt++;
    bus.addr = 32'h0000_1C10; #1;
    check_cnt++; if (bus.sel !== 1'b0) $display("FAIL sel_upper got=%b exp=0", bus.sel); else pass_cnt++;
    bus.addr = BASE + 32'h1C; #1;
    check_cnt++; if (bus.sel !== 1'b1) $display("FAIL sel_top got=%b exp=1", bus.sel); else pass_cnt++;
    sw = 10'h155;
    repeat (3) @(negedge clock);
    wr(OFF_SW, 32'hFFFF_FFFF);
    rd(OFF_SW);
    check_cnt++; if (bus.rdata !== 32'h155) $display("FAIL sw_ro got=%h exp=%h", bus.rdata, 32'h155); else pass_cnt++;
    check_cnt++; if (led !== 10'h2A5) $display("FAIL led_after_ro got=%h exp=%h", led, 10'h2A5); else pass_cnt++;
  endtask

  task automatic test_hex();
    wr(OFF_HEXVAL, 32'h0012_3456);
    wr(OFF_BLANK, 32'h0);
    check_cnt++; if (hex !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02})
      $display("FAIL hex_123456 got=%h exp=%h", hex, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}); else pass_cnt++;
    wr(OFF_HEXVAL, 32'h00AB_CDEF);
    wr(OFF_BLANK, 32'h05);
    check_cnt++; if (hex !== {7'h08, 7'h03, 7'h46, 7'h7F, 7'h06, 7'h7F})
      $display("FAIL hex_blank got=%h exp=%h", hex, {7'h08, 7'h03, 7'h46, 7'h7F, 7'h06, 7'h7F}); else pass_cnt++;
  endtask

  task automatic test_key_debounce();
    wr(OFF_IE, 32'h1);
    @(negedge clock); key = 4'hE;
    repeat (3) @(negedge clock); key = 4'hF;
    repeat (8) @(negedge clock);
    rd(OFF_KEY);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL key_short got=%h exp=0", bus.rdata); else pass_cnt++;
    rd(OFF_EDGE);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL edge_short got=%h exp=0", bus.rdata); else pass_cnt++;
    @(negedge clock); key = 4'hE;
    repeat (5) @(negedge clock);
    rd(OFF_KEY);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL key_early got=%h exp=0", bus.rdata); else pass_cnt++;
    @(negedge clock); #1;
    check_cnt++; if (bus.rdata !== 32'h1) $display("FAIL key_press got=%h exp=1", bus.rdata); else pass_cnt++;
    rd(OFF_EDGE);
    check_cnt++; if (bus.rdata !== 32'h1) $display("FAIL edge_press got=%h exp=1", bus.rdata); else pass_cnt++;
    check_cnt++; if (bus.irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", bus.irq); else pass_cnt++;
    wr(OFF_EDGE, 32'h1);
    check_cnt++; if (bus.irq !== 1'b0) $display("FAIL irq_clr got=%b exp=0", bus.irq); else pass_cnt++;
    key = 4'hF;
    repeat (8) @(negedge clock);
    rd(OFF_KEY);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL key_release got=%h exp=0", bus.rdata); else pass_cnt++;
    rd(OFF_EDGE);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL edge_release got=%h exp=0", bus.rdata); else pass_cnt++;
  endtask

  task automatic test_w1c_collision();
    @(negedge clock); key = 4'hD;
    repeat (5) @(negedge clock);
    rd(OFF_KEY);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL coll_key_pre got=%h exp=0", bus.rdata); else pass_cnt++;
    bus.addr = BASE + 32'(OFF_EDGE); bus.wdata = 32'h2; bus.we = 1'b1;
    @(negedge clock);
    bus.we = 1'b0; #1;
    check_cnt++; if (bus.rdata !== 32'h2) $display("FAIL coll_edge got=%h exp=2", bus.rdata); else pass_cnt++;
    check_cnt++; if (bus.irq !== 1'b0) $display("FAIL irq_masked got=%b exp=0", bus.irq); else pass_cnt++;
    wr(OFF_IE, 32'h2);
    check_cnt++; if (bus.irq !== 1'b1) $display("FAIL irq_ie1 got=%b exp=1", bus.irq); else pass_cnt++;
    wr(OFF_EDGE, 32'h2);
    check_cnt++; if (bus.irq !== 1'b0) $display("FAIL irq_ie1_clr got=%b exp=0", bus.irq); else pass_cnt++;
    key = 4'hF;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_timer();
    wr(OFF_TIMER, 32'hFFFF_FFFF);
    rd(OFF_TIMER);
    check_cnt++; if (bus.rdata !== 32'hFFFF_FFFF) $display("FAIL timer_load got=%h exp=%h", bus.rdata, 32'hFFFF_FFFF); else pass_cnt++;
    repeat (3) @(negedge clock); #1;
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL timer_wrap got=%h exp=0", bus.rdata); else pass_cnt++;
    repeat (15) @(negedge clock); #1;
    check_cnt++; if (bus.rdata !== 32'h5) $display("FAIL timer_5 got=%h exp=5", bus.rdata); else pass_cnt++;
    wr(OFF_TIMER, 32'd100);
    repeat (2) @(negedge clock);
    bus.addr = BASE + 32'(OFF_TIMER); bus.wdata = 32'd200; bus.we = 1'b1;
    @(negedge clock);
    bus.we = 1'b0; #1;
    check_cnt++; if (bus.rdata !== 32'd200) $display("FAIL timer_prec got=%0d exp=200", bus.rdata); else pass_cnt++;
    repeat (2) @(negedge clock); #1;
    check_cnt++; if (bus.rdata !== 32'd200) $display("FAIL timer_presc0 got=%0d exp=200", bus.rdata); else pass_cnt++;
    @(negedge clock); #1;
    check_cnt++; if (bus.rdata !== 32'd201) $display("FAIL timer_tick got=%0d exp=201", bus.rdata); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    wr(OFF_IE, 32'hF);
    wr(OFF_BLANK, 32'h0);
    @(negedge clock); key = 4'h7;
    repeat (8) @(negedge clock); #1;
    check_cnt++; if (bus.irq !== 1'b1) $display("FAIL pre_reset_irq got=%b exp=1", bus.irq); else pass_cnt++;
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check_cnt++; if (bus.irq !== 1'b0) $display("FAIL areset_irq got=%b exp=0", bus.irq); else pass_cnt++;
    check_cnt++; if (led !== 10'h0) $display("FAIL areset_led got=%h exp=0", led); else pass_cnt++;
    check_cnt++; if (hex !== {HEX_N{7'h7F}}) $display("FAIL areset_hex got=%h exp=%h", hex, {HEX_N{7'h7F}}); else pass_cnt++;
    rd(OFF_TIMER);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL areset_timer got=%h exp=0", bus.rdata); else pass_cnt++;
    rd(OFF_EDGE);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL areset_edge got=%h exp=0", bus.rdata); else pass_cnt++;
    rd(OFF_IE);
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL areset_ie got=%h exp=0", bus.rdata); else pass_cnt++;
    @(negedge clock);
    resetn = 1'b1;
    rd(OFF_KEY);
    repeat (5) @(negedge clock); #1;
    check_cnt++; if (bus.rdata !== 32'h0) $display("FAIL rst_deb_early got=%h exp=0", bus.rdata); else pass_cnt++;
    @(negedge clock); #1;
    check_cnt++; if (bus.rdata !== 32'h8) $display("FAIL rst_deb_press got=%h exp=8", bus.rdata); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_led_sel();
    test_hex();
    test_key_debounce();
    test_w1c_collision();
    test_timer();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/sc_mmio_ctrl.md
SC_MMIO_CTRL -- requirements
Module: sc_mmio_ctrl

Interface
REQ-001 Parameters SHALL be, each as name, default, meaning:
  BASE_ADDR, 32'h0000_0C00, word-aligned base of the 8-word register window.
  SW_W, 10, switch count (1..32).
  KEY_W, 4, push-key count (1..32).
  LED_W, 10, LED count (1..32).
  HEX_N, 6, seven-segment digit count (1..8).
  DEB_CYCLES, 50000, clocks a key must be stable before the debounced level changes (>=2).
  TICK_DIV, 50000, clocks per timer tick (>=1).
REQ-002 Ports SHALL be, each as name, direction, width, meaning:
  clock  in  1  sole clock, rising edge.
  resetn  in  1  asynchronous, active-low reset.
  addr  in  32  CPU byte address.
  wdata  in  32  CPU write data.
  we  in  1  CPU write strobe.
  sel  out  1  addr falls inside the window.
  rdata  out  32  read data.
  irq  out  1  key-press interrupt request.
  sw  in  SW_W  raw switches, asynchronous.
  key  in  KEY_W  raw keys, active-low, asynchronous.
  led  out  LED_W  LED drive, active-high.
  hex  out  7*HEX_N  segments, active-low; digit i on bits [7i+6:7i], segment a at bit 0.

Function
REQ-003 sel SHALL be 1 iff addr[31:5] == BASE_ADDR[31:5]; addr[1:0] SHALL be ignored.
REQ-004 Word offsets SHALL be: 0x00 SW (RO), 0x04 KEY (RO), 0x08 EDGE (RW1C), 0x0C IE (RW), 0x10 LED (RW), 0x14 HEXVAL (RW), 0x18 BLANK (RW), 0x1C TIMER (RW).
REQ-005 rdata SHALL be combinational from addr (zero-latency read) and SHALL be 0 when sel=0; unused upper bits SHALL read 0.
REQ-006 Writes SHALL take effect on the rising clock edge when we=1 and sel=1; writes to RO offsets SHALL be ignored.
REQ-007 sw and key SHALL each pass through a 2-flop synchroniser before any use.
REQ-008 Each key SHALL have its own stability counter; the debounced level SHALL change only after the synchronised, inverted key differs from it for DEB_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-009 KEY SHALL read the debounced levels, with 1 = pressed.
REQ-010 A debounced 0->1 transition SHALL set the corresponding EDGE bit; writing 1 SHALL clear a bit; when a set and a clear occur in the same cycle, the set SHALL win.
REQ-011 irq SHALL equal |(EDGE & IE) and SHALL be registered-free: a combinational function of the registers only.
REQ-012 Each digit i SHALL show the hex glyph (0-F) of HEXVAL[4i+3:4i], or all segments off (7'h7F) when BLANK[i]=1.
REQ-013 A prescaler SHALL count 0..TICK_DIV-1; on wrap, TIMER SHALL increment by 1 and wrap from 0xFFFF_FFFF to 0.
REQ-014 A write to TIMER SHALL load wdata and zero the prescaler; that write SHALL take precedence over a coincident tick.

Reset
REQ-015 On resetn=0, all of the following SHALL be cleared immediately, regardless of clock: EDGE, IE, LED, HEXVAL, TIMER, the prescaler and the debounce counters.
REQ-016 On reset, BLANK SHALL become all ones, so hex = all 7'h7F, and led SHALL become 0.
REQ-017 On reset, the key synchroniser flops SHALL go to 1 (released), the sw synchroniser flops SHALL go to 0, and the debounced levels SHALL go to 0; irq SHALL go to 0.
REQ-018 Release of resetn mid-bounce SHALL start debouncing from count 0; no spurious EDGE bit SHALL be set.

Structure
REQ-019 Package sc_mmio_pkg SHALL hold the register offset constants and the 16-entry active-low glyph table.
REQ-020 Sub-module sc_hex7seg (4-bit value + blank in, 7-bit segments out) SHALL be instantiated HEX_N times via generate.

Verification
REQ-021 Write LED=0x2A5 at BASE+0x10 -> led=10'h2A5 next cycle; rdata at BASE+0x10 = 0x0000_02A5.
REQ-022 Write HEXVAL=0x00123456, BLANK=0 -> hex digits 5..0 show 1,2,3,4,5,6 (digit0 = 7'h02).
REQ-023 DEB_CYCLES=4: key[0] low for 3 cycles -> no change; held low for 6 -> KEY=0x1 and EDGE=0x1; with IE=1, irq=1; write EDGE=1 -> irq=0.
REQ-024 W1C write to EDGE in the same cycle as a new press on the same key -> EDGE bit remains 1.
REQ-025 TICK_DIV=3: load TIMER=0xFFFF_FFFF -> after 3 cycles it reads 0; with no further writes it reads 5 after 15 more cycles.
REQ-026 Assert resetn mid-run -> all registers return to their reset values asynchronously; hex=all 7'h7F; irq=0.
